// File: rtl/csd_gain_scaler_pipe.sv
// Two-stage pipelined multi-channel CSD gain scaler (K, K^2, -K, bypass) with valid/ready flow.
// Optional build macro CSD_ROUND_EN: round-half-up per term instead of floor truncation.
module csd_gain_scaler_pipe #(
  parameter int DATA_W = 17,
  parameter int NCH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DATA_W-1:0] out_data
);

  localparam int SW = DATA_W + 2;

  localparam logic [1:0] MODE_BYP = 2'b00;
  localparam logic [1:0] MODE_K   = 2'b01;
  localparam logic [1:0] MODE_K2  = 2'b10;
  localparam logic [1:0] MODE_NK  = 2'b11;

  function automatic logic signed [SW-1:0] sext(input logic signed [DATA_W-1:0] x);
    return SW'(x);
  endfunction

  function automatic logic signed [SW-1:0] term(input logic signed [DATA_W-1:0] x,
                                                input int s);
    logic signed [SW-1:0] xe;
    xe = sext(x);
`ifdef CSD_ROUND_EN
    xe = xe + (SW'(1) <<< (s - 1));
`endif
    return xe >>> s;
  endfunction

  function automatic logic [DATA_W-1:0] trunc_out(input logic signed [SW-1:0] v);
    return DATA_W'(v);
  endfunction

  logic                        vld_p1;
  logic                        vld_p2;
  logic                        adv_p1;
  logic                        adv_p2;
  logic [1:0]                  mode_p1;
  logic signed [DATA_W-1:0]    x_c;
  logic signed [SW-1:0]        lo_c   [NCH];
  logic signed [SW-1:0]        hi_c   [NCH];
  logic signed [SW-1:0]        lo_p1  [NCH];
  logic signed [SW-1:0]        hi_p1  [NCH];
  logic signed [SW-1:0]        sum_c  [NCH];
  logic [NCH*DATA_W-1:0]       data_p2;

  // S2 advances when it is empty or being drained; S1 then follows into any gap.
  assign adv_p2    = !vld_p2 || out_ready;
  assign adv_p1    = !vld_p1 || adv_p2;
  assign in_ready  = adv_p1;
  assign out_valid = vld_p2;
  assign out_data  = data_p2;

  // Stage 0 -> 1: split each constant into low-shift (<=6) and high-shift partial sums.
  always_comb begin
    x_c = '0;
    for (int c = 0; c < NCH; c++) begin
      lo_c[c] = '0;
      hi_c[c] = '0;
      x_c     = $signed(in_data[c*DATA_W +: DATA_W]);
      case (in_mode)
        MODE_K, MODE_NK: begin
          lo_c[c] = term(x_c, 1) + term(x_c, 3) - term(x_c, 6);
          hi_c[c] = term(x_c, 14) - term(x_c, 9) - term(x_c, 12);
        end
        MODE_K2: begin
          lo_c[c] = term(x_c, 1) - term(x_c, 3) - term(x_c, 6);
          hi_c[c] = term(x_c, 7) + term(x_c, 9) - term(x_c, 11) + term(x_c, 13);
        end
        default: begin
          lo_c[c] = sext(x_c);
          hi_c[c] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p1 <= MODE_BYP;
      for (int c = 0; c < NCH; c++) begin
        lo_p1[c] <= '0;
        hi_p1[c] <= '0;
      end
    end else if (in_valid && adv_p1) begin
      mode_p1 <= in_mode;
      for (int c = 0; c < NCH; c++) begin
        lo_p1[c] <= lo_c[c];
        hi_p1[c] <= hi_c[c];
      end
    end
  end

  // Stage 1 -> 2: combine partial sums; -K reuses the K sum and negates it here.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      sum_c[c] = lo_p1[c] + hi_p1[c];
      if (mode_p1 == MODE_NK) sum_c[c] = -sum_c[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p2 <= '0;
    end else if (adv_p2 && vld_p1) begin
      for (int c = 0; c < NCH; c++) data_p2[c*DATA_W +: DATA_W] <= trunc_out(sum_c[c]);
    end
  end

endmodule

// File: tb/tb_csd_gain_scaler_pipe.sv
// Scoreboard bench for csd_gain_scaler_pipe: directed beats push expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_csd_gain_scaler_pipe;

  localparam int DW  = 17;
  localparam int NCH = 2;

`ifdef CSD_ROUND_EN
  localparam int ONE_K = 1;
`else
  localparam int ONE_K = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_mode;
  logic [NCH*DW-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [NCH*DW-1:0]   out_data;

  typedef struct {
    int c0;
    int c1;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  bit   held_v = 0;
  logic [NCH*DW-1:0] held_d;

  csd_gain_scaler_pipe #(.DATA_W(DW), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [NCH*DW-1:0] pack(input int a, input int b);
    logic [DW-1:0] la;
    logic [DW-1:0] lb;
    la = DW'(a);
    lb = DW'(b);
    return {lb, la};
  endfunction

  // Called right after posedge+#1; returns at posedge+#1 after the beat is taken.
  task automatic send(input logic [1:0] mode, input int a, input int b,
                      input int e0, input int e1, input bit lat);
    exp_t e;
    bit   ok;
    ok       = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = pack(a, b);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.c0 = e0; e.c1 = e1; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_v = 0;
    end else begin
      if (out_valid && !out_ready) begin
        if (held_v) check("stall_stable", int'(out_data), int'(held_d));
        held_v = 1;
        held_d = out_data;
      end else begin
        held_v = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", int'(out_data), -1);
        end else begin
          e = sb.pop_front();
          check("ch0", int'($signed(out_data[DW-1:0])), e.c0);
          check("ch1", int'($signed(out_data[2*DW-1:DW])), e.c1);
          if (e.lat) check("latency", cyc - e.acc, 2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Mode sweep and boundaries at full throughput.
    send(2'b01,  16384, -16384,  9949,  -9949, 1);
    send(2'b10,  16384, -16384,  6042,  -6042, 1);
    send(2'b11,  16384, -16384, -9949,   9949, 1);
    send(2'b00,  16384, -16384, 16384, -16384, 1);
    send(2'b11, -65536,      0, 39796,      0, 1);
    send(2'b01, -65536,  16384, -39796,  9949, 1);
    send(2'b01,      1,     -1, ONE_K,      0, 1);
    drain();

    // Backpressure: 6 beats, alternating modes, output stalled for 5 cycles.
    out_ready = 1'b0;
    fork
      begin
        send(2'b01,  16384, -16384,   9949,  -9949, 0);
        send(2'b10,  32768,  16384,  12084,   6042, 0);
        send(2'b01, -32768,      0, -19898,      0, 0);
        send(2'b10, -16384,  32768,  -6042,  12084, 0);
        send(2'b01,      0,  32768,      0,  19898, 0);
        send(2'b10,  16384, -32768,   6042, -12084, 0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_low", int'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Bubble collapse: beat held in S2 with S1 empty still admits one more.
    out_ready = 1'b0;
    send(2'b00, 16384, -16384, 16384, -16384, 0);
    @(posedge clk);
    #1;
    check("bubble_ready_hi", int'(in_ready), 1);
    send(2'b11, 16384, -16384, -9949, 9949, 0);
    check("bubble_ready_lo", int'(in_ready), 0);
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(2'b01, 16384, -16384, 9949, -9949, 0);
    send(2'b01, 16384, -16384, 9949, -9949, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", int'(out_valid), 0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
